// File: rtl/clks_alot_tx_scheduler.sv
// Transmit-side sequencer for the clks_alot link: generates clk_out, frames it with long/short pauses.
// Optional status outputs (frames_sent, underrun) are enabled by defining CLKS_ALOT_TX_STATUS_EN.
module clks_alot_tx_scheduler #(
  parameter int HALF_PERIOD        = 32,
  parameter int NEGEDGES_PER_FRAME = 32,
  parameter int SHORT_PAUSE_LEN    = 384,
  parameter int LONG_PAUSE_LEN     = 3840,
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     enable,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  logic                     long_pause_req,
  output logic                     clk_out,
  output logic                     negedge_strobe,
  output logic                     frame_done,
  output logic                     pause_active,
  output logic                     pause_long,
  output logic [COUNTER_WIDTH-1:0] pause_duration,
  output logic                     busy
`ifdef CLKS_ALOT_TX_STATUS_EN
  ,
  output logic [COUNTER_WIDTH-1:0] frames_sent,
  output logic                     underrun
`endif
);

  localparam int NEG_W  = $clog2(NEGEDGES_PER_FRAME + 1);
  localparam int HALF_W = $clog2(HALF_PERIOD + 1);
  localparam logic [HALF_W-1:0]        HALF_LAST  = HALF_W'(HALF_PERIOD - 1);
  localparam logic [NEG_W-1:0]         NEG_LAST   = NEG_W'(NEGEDGES_PER_FRAME - 1);
  localparam logic [COUNTER_WIDTH-1:0] LONG_LAST  = COUNTER_WIDTH'(LONG_PAUSE_LEN - 1);
  localparam logic [COUNTER_WIDTH-1:0] SHORT_LAST = COUNTER_WIDTH'(SHORT_PAUSE_LEN - 1);
  localparam logic [COUNTER_WIDTH-1:0] DUR_MAX    = {COUNTER_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LONG_PAUSE  = 2'd1,
    ST_RUN         = 2'd2,
    ST_SHORT_PAUSE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     clk_out_q, clk_out_d;
  logic [HALF_W-1:0]        half_q, half_d;
  logic [NEG_W-1:0]         neg_q, neg_d;
  logic [COUNTER_WIDTH-1:0] dur_q, dur_d;
  logic                     long_q, long_d;
  logic                     strobe_q, strobe_d;
  logic                     done_q, done_d;
  logic                     in_pause_s;
  logic                     at_decision_s;
  logic                     ready_s;
  logic [COUNTER_WIDTH-1:0] dur_inc_s;
`ifdef CLKS_ALOT_TX_STATUS_EN
  logic [COUNTER_WIDTH-1:0] frames_q;
  logic                     underrun_q;
  logic                     underrun_set_s;
`endif

  assign in_pause_s    = (state_q == ST_LONG_PAUSE) || (state_q == ST_SHORT_PAUSE);
  assign at_decision_s = in_pause_s &&
                         (dur_q >= ((state_q == ST_LONG_PAUSE) ? LONG_LAST : SHORT_LAST));
  assign dur_inc_s     = (dur_q == DUR_MAX) ? dur_q : dur_q + COUNTER_WIDTH'(1);
  // A pending long-pause request at a short decision point blocks the handshake.
  assign ready_s       = at_decision_s && enable &&
                         !((state_q == ST_SHORT_PAUSE) && long_pause_req);

  assign frame_ready    = ready_s;
  assign clk_out        = clk_out_q;
  assign negedge_strobe = strobe_q;
  assign frame_done     = done_q;
  assign pause_active   = in_pause_s;
  assign pause_long     = long_q;
  assign pause_duration = dur_q;
  assign busy           = (state_q != ST_IDLE);
`ifdef CLKS_ALOT_TX_STATUS_EN
  assign frames_sent    = frames_q;
  assign underrun       = underrun_q;
`endif

  always_comb begin
    state_d   = state_q;
    clk_out_d = clk_out_q;
    half_d    = half_q;
    neg_d     = neg_q;
    dur_d     = dur_q;
    long_d    = long_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
`ifdef CLKS_ALOT_TX_STATUS_EN
    underrun_set_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        clk_out_d = 1'b0;
        if (enable) begin
          state_d = ST_LONG_PAUSE;
          dur_d   = '0;
          long_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LONG_PAUSE, ST_SHORT_PAUSE: begin
        clk_out_d = 1'b0;
        if (!at_decision_s) begin
          dur_d = dur_inc_s;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else if (!ready_s) begin
          state_d = ST_LONG_PAUSE;
          dur_d   = '0;
          long_d  = 1'b1;
        end else if (frame_valid) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
          half_d    = '0;
          neg_d     = '0;
        end else if (state_q == ST_SHORT_PAUSE) begin
          state_d = ST_LONG_PAUSE;
          dur_d   = '0;
          long_d  = 1'b1;
`ifdef CLKS_ALOT_TX_STATUS_EN
          underrun_set_s = 1'b1;
`endif
        end else begin
          // Long pause overruns: keep counting, every later cycle is a decision point.
          dur_d = dur_inc_s;
        end
      end
      ST_RUN: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (clk_out_q) begin
            clk_out_d = 1'b0;
            strobe_d  = 1'b1;
            neg_d     = neg_q + NEG_W'(1);
            if (neg_q == NEG_LAST) begin
              // Final negedge doubles as short-pause cycle 0.
              state_d = ST_SHORT_PAUSE;
              done_d  = 1'b1;
              dur_d   = '0;
              long_d  = 1'b0;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            clk_out_d = 1'b1;
          end
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      clk_out_q <= 1'b0;
      half_q    <= '0;
      neg_q     <= '0;
      dur_q     <= '0;
      long_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef CLKS_ALOT_TX_STATUS_EN
      frames_q   <= '0;
      underrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_out_q <= clk_out_d;
      half_q    <= half_d;
      neg_q     <= neg_d;
      dur_q     <= dur_d;
      long_q    <= long_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
`ifdef CLKS_ALOT_TX_STATUS_EN
      frames_q   <= frames_q + COUNTER_WIDTH'(done_d);
      underrun_q <= underrun_q | underrun_set_s;
`endif
    end
  end

endmodule

// File: tb/tb_clks_alot_tx_scheduler.sv
// Directed self-checking bench for clks_alot_tx_scheduler (default parameters).
module tb_clks_alot_tx_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic        frame_valid;
  logic        frame_ready;
  logic        long_pause_req;
  logic        clk_out;
  logic        negedge_strobe;
  logic        frame_done;
  logic        pause_active;
  logic        pause_long;
  logic [31:0] pause_duration;
  logic        busy;
`ifdef CLKS_ALOT_TX_STATUS_EN
  logic [31:0] frames_sent;
  logic        underrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int rise1    = 0;

  clks_alot_tx_scheduler dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .enable         (enable),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .long_pause_req (long_pause_req),
    .clk_out        (clk_out),
    .negedge_strobe (negedge_strobe),
    .frame_done     (frame_done),
    .pause_active   (pause_active),
    .pause_long     (pause_long),
    .pause_duration (pause_duration),
    .busy           (busy)
`ifdef CLKS_ALOT_TX_STATUS_EN
    ,
    .frames_sent    (frames_sent),
    .underrun       (underrun)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cyc();
    @(posedge sys_clk);
    #1;
    cycle++;
  endtask

  // Checks a whole pause of len cycles; ends on the first cycle after it.
  task automatic pause_phase(input int len, input logic lng, input logic ready_last, output int errs);
    logic exp_ready;
    errs = 0;
    for (int d = 0; d < len; d++) begin
      exp_ready = (d == len - 1) ? ready_last : 1'b0;
      if (clk_out !== 1'b0 || pause_active !== 1'b1 || pause_long !== lng ||
          pause_duration !== 32'(d) || frame_ready !== exp_ready || busy !== 1'b1) begin
        if (errs == 0)
          $display("  pause cycle %0d: clk=%b act=%b long=%b dur=%0d rdy=%b (exp rdy %b)",
                   d, clk_out, pause_active, pause_long, pause_duration, frame_ready, exp_ready);
        errs++;
      end
      cyc();
    end
  endtask

  // Checks RUN from cycle 0 up to the final negedge (short-pause cycle 0).
  task automatic run_frame(input int drop_at, output int errs, output int strobes, output int dones);
    logic exp_clk, exp_strobe, exp_done;
    errs = 0; strobes = 0; dones = 0;
    for (int c = 0; c <= 2016; c++) begin
      exp_clk    = ((c / 32) % 2) == 0;
      exp_strobe = (c >= 32) && ((c % 64) == 32);
      exp_done   = (c == 2016);
      if (clk_out !== exp_clk || negedge_strobe !== exp_strobe || frame_done !== exp_done ||
          frame_ready !== 1'b0 || busy !== 1'b1 || pause_active !== exp_done) begin
        if (errs == 0)
          $display("  run cycle %0d: clk=%b stb=%b done=%b rdy=%b act=%b", c, clk_out,
                   negedge_strobe, frame_done, frame_ready, pause_active);
        errs++;
      end
      if (negedge_strobe === 1'b1) strobes++;
      if (frame_done === 1'b1) dones++;
      if (c == drop_at) enable = 1'b0;
      if (c < 2016) cyc();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; enable = 1'b0; frame_valid = 1'b0; long_pause_req = 1'b0;
    cyc(); cyc();
    sys_rst = 1'b0;
    cyc();
    n_checks++;
    if ({clk_out, negedge_strobe, frame_done, pause_active, pause_long, busy, frame_ready} !== 7'b0 ||
        pause_duration !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got clk=%b stb=%b done=%b act=%b long=%b busy=%b rdy=%b dur=%0d, want all 0",
               clk_out, negedge_strobe, frame_done, pause_active, pause_long, busy, frame_ready, pause_duration);
    end
`ifdef CLKS_ALOT_TX_STATUS_EN
    n_checks++;
    if (frames_sent !== 32'd0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got frames=%0d underrun=%b, want 0 0", frames_sent, underrun);
    end
`endif
  endtask

  task automatic test_first_frame();
    int errs, strobes, dones;
    enable = 1'b1; frame_valid = 1'b1;
    cyc();
    pause_phase(3840, 1'b1, 1'b1, errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL first_long_pause: %0d bad cycles, want 0", errs); end
    rise1 = cycle;
    run_frame(-1, errs, strobes, dones);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL first_frame_wave: %0d bad cycles, want 0", errs); end
    n_checks++;
    if (strobes !== 32 || dones !== 1) begin
      n_fail++; $display("FAIL first_frame_counts: strobes=%0d dones=%0d, want 32 1", strobes, dones);
    end
    n_checks++;
    if (pause_duration !== 32'd0 || pause_long !== 1'b0) begin
      n_fail++; $display("FAIL frame_end_pause: dur=%0d long=%b, want 0 0", pause_duration, pause_long);
    end
  endtask

  task automatic test_back_to_back();
    int errs, strobes, dones;
    pause_phase(384, 1'b0, 1'b1, errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL b2b_short_pause: %0d bad cycles, want 0", errs); end
    n_checks++;
    if (cycle - rise1 !== 2400 || clk_out !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rise_spacing: got %0d clk=%b, want 2400 1", cycle - rise1, clk_out);
    end
    run_frame(-1, errs, strobes, dones);
    n_checks++;
    if (errs !== 0 || strobes !== 32 || dones !== 1) begin
      n_fail++; $display("FAIL b2b_frame: errs=%0d strobes=%0d dones=%0d, want 0 32 1", errs, strobes, dones);
    end
`ifdef CLKS_ALOT_TX_STATUS_EN
    n_checks++;
    if (frames_sent !== 32'd2) begin n_fail++; $display("FAIL frames_sent: got %0d want 2", frames_sent); end
`endif
  endtask

  task automatic test_underrun();
    int errs, strobes, dones;
    frame_valid = 1'b0;
    pause_phase(384, 1'b0, 1'b1, errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL underrun_short: %0d bad cycles, want 0", errs); end
    errs = 0;
    for (int d = 0; d < 4999; d++) begin
      if (pause_long !== 1'b1 || pause_duration !== 32'(d) || clk_out !== 1'b0 ||
          frame_ready !== (d >= 3839)) errs++;
      cyc();
    end
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL underrun_long_count: %0d bad cycles, want 0", errs); end
    frame_valid = 1'b1;
    #1;
    n_checks++;
    if (frame_ready !== 1'b1 || pause_duration !== 32'd4999) begin
      n_fail++; $display("FAIL late_handshake: rdy=%b dur=%0d, want 1 4999", frame_ready, pause_duration);
    end
`ifdef CLKS_ALOT_TX_STATUS_EN
    n_checks++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b want 1", underrun); end
`endif
    cyc();
    run_frame(-1, errs, strobes, dones);
    n_checks++;
    if (errs !== 0 || strobes !== 32) begin
      n_fail++; $display("FAIL underrun_frame: errs=%0d strobes=%0d, want 0 32", errs, strobes);
    end
  endtask

  task automatic test_long_req();
    int errs, strobes, dones;
    long_pause_req = 1'b1; frame_valid = 1'b1;
    pause_phase(384, 1'b0, 1'b0, errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL req_short_no_ready: %0d bad cycles, want 0", errs); end
    // Request stays high through the long pause, where it must be ignored.
    pause_phase(3840, 1'b1, 1'b1, errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL req_long_pause: %0d bad cycles, want 0", errs); end
    long_pause_req = 1'b0;
    run_frame(-1, errs, strobes, dones);
    n_checks++;
    if (errs !== 0 || strobes !== 32) begin
      n_fail++; $display("FAIL req_frame: errs=%0d strobes=%0d, want 0 32", errs, strobes);
    end
  endtask

  task automatic test_enable_drop();
    int errs, strobes, dones;
    pause_phase(384, 1'b0, 1'b1, errs);
    run_frame(608, errs, strobes, dones);
    n_checks++;
    if (errs !== 0 || strobes !== 32 || dones !== 1) begin
      n_fail++; $display("FAIL drop_frame: errs=%0d strobes=%0d dones=%0d, want 0 32 1", errs, strobes, dones);
    end
    pause_phase(384, 1'b0, 1'b0, errs);
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL drop_short_pause: %0d bad cycles, want 0", errs); end
    n_checks++;
    if (busy !== 1'b0 || pause_active !== 1'b0 || clk_out !== 1'b0 || pause_duration !== 32'd383) begin
      n_fail++; $display("FAIL drop_idle: busy=%b act=%b clk=%b dur=%0d, want 0 0 0 383",
                         busy, pause_active, clk_out, pause_duration);
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_ready !== 1'b0 || busy !== 1'b0) errs++;
      cyc();
    end
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL idle_stays: %0d bad cycles, want 0", errs); end
  endtask

  task automatic test_reset_mid_run();
    int errs;
    enable = 1'b1;
    cyc();
    pause_phase(3840, 1'b1, 1'b1, errs);
    for (int i = 0; i < 5; i++) cyc();
    n_checks++;
    if (clk_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_clk: got %b want 1", clk_out); end
    sys_rst = 1'b1;
    cyc();
    n_checks++;
    if ({clk_out, negedge_strobe, frame_done, pause_active, pause_long, busy, frame_ready} !== 7'b0 ||
        pause_duration !== 32'd0) begin
      n_fail++; $display("FAIL mid_run_reset: clk=%b act=%b long=%b busy=%b dur=%0d, want all 0",
                         clk_out, pause_active, pause_long, busy, pause_duration);
    end
    sys_rst = 1'b0;
    cyc();
    pause_phase(3840, 1'b1, 1'b1, errs);
    n_checks++;
    if (errs !== 0 || clk_out !== 1'b1) begin
      n_fail++; $display("FAIL restart_long_pause: errs=%0d clk=%b, want 0 1", errs, clk_out);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_underrun();
    test_long_req();
    test_enable_drop();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clks_alot_tx_scheduler.md
Name: clks_alot_tx_scheduler

Overview:
Transmit-side sequencer for the clks_alot link. Generates the outbound interface clock and frames it with long and short pauses, which the receive-side recovery logic detects and locks to. Accepts one frame per valid/ready handshake and emits a strobe on every clock negedge so the datapath can shift addr/data bits. Sits between the frame source and the interface pin drivers.

Parameters:
HALF_PERIOD, 32, sys_clk cycles per clk_out high or low phase (SYS_CLOCK_MULTIPLE/2)
NEGEDGES_PER_FRAME, 32, clk_out negedges per frame (TRANSMITTED_BITS*CYCLES_PER_BIT)
SHORT_PAUSE_LEN, 384, sys_clk cycles of a short pause (TARGET_SHORT_LENGTH)
LONG_PAUSE_LEN, 3840, sys_clk cycles of a long pause (TARGET_LONG_LENGTH)
COUNTER_WIDTH, 32, pause_duration width

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, synchronous, active-high
enable  in  1  link enable
frame_valid  in  1  source has a frame ready
frame_ready  out  1  frame accepted this cycle (valid&ready = handshake)
long_pause_req  in  1  force a long pause at the next decision point
clk_out  out  1  interface clock, registered
negedge_strobe  out  1  one-cycle pulse coincident with each clk_out 1->0
frame_done  out  1  one-cycle pulse on the final negedge of a frame
pause_active  out  1  clk_out held low in a pause
pause_long  out  1  current or last pause type: 1 long, 0 short
pause_duration  out  COUNTER_WIDTH  cycles since pause start, saturating at all-ones
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation aborts immediately; clk_out low on the next cycle.
- States: IDLE, LONG_PAUSE, RUN, SHORT_PAUSE.
- IDLE: clk_out=0. If enable=1, the next cycle enters LONG_PAUSE with pause_long=1.
- Pause states: clk_out=0, pause_active=1. pause_duration is 0 on the first pause cycle and increments each cycle.
- Decision point: the cycle where pause_duration >= LEN-1 (LONG_PAUSE_LEN or SHORT_PAUSE_LEN).
- frame_ready is combinational and high only at a decision point with enable=1, and in SHORT_PAUSE also requires long_pause_req=0.
- At a decision point, priority order:
  - enable=0: go to IDLE.
  - SHORT_PAUSE with long_pause_req=1: go to LONG_PAUSE, counter restarts, frame not accepted. This also applies when frame_valid=1.
  - frame_valid=1: handshake, then go to RUN.
  - Otherwise: SHORT_PAUSE converts to LONG_PAUSE with counter restart. LONG_PAUSE stays put, the counter keeps counting, and every following cycle is a decision point.
- RUN: clk_out=1 on the first RUN cycle. clk_out toggles every HALF_PERIOD cycles. Negedge k occurs at RUN cycle 64k-32 for the defaults.
  - negedge_strobe=1 in each cycle where clk_out is 0 and was 1.
  - On negedge NEGEDGES_PER_FRAME, frame_done=1 and the same cycle is SHORT_PAUSE cycle 0 (pause_duration=0, pause_long=0).
  - Low time after a frame is exactly SHORT_PAUSE_LEN cycles.
  - Frame-to-frame rising-edge spacing is 2016+384=2400 cycles.
- enable deasserted during RUN: the frame completes, then the short pause completes, then IDLE.
- long_pause_req is sampled only at SHORT_PAUSE decision points and is ignored elsewhere.
- Negedge counter width is clog2(NEGEDGES_PER_FRAME+1). It clears on RUN entry and never wraps mid-frame.
- pause_duration saturates and does not wrap. It holds its last value outside pauses.

Optional Feature:
CLKS_ALOT_TX_STATUS_EN
- Defined: adds outputs frames_sent (COUNTER_WIDTH, wraps, increments on frame_done) and underrun (sticky). underrun sets when a SHORT_PAUSE decision point has enable=1, long_pause_req=0 and frame_valid=0, and clears only on sys_rst.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Reset, then enable=1 with frame_valid=1 held -> pause_long=1 for 3840 cycles; frame_ready pulses on cycle 3840 after LONG_PAUSE entry; clk_out rises next cycle; 32 negedge_strobes spaced 64 cycles apart; frame_done on the 32nd.
2. Back-to-back frames -> clk_out low exactly 384 cycles between frames; rising edges 2400 cycles apart; frame_ready once per frame.
3. frame_valid=0 at a short-pause decision point -> LONG_PAUSE with pause_duration restarting at 0. Raise frame_valid 5000 cycles later -> accepted at once, pause_duration=4999 at the handshake. With CLKS_ALOT_TX_STATUS_EN, underrun=1.
4. long_pause_req=1 and frame_valid=1 together at a short decision point -> no handshake; 3840-cycle long pause, then accept.
5. enable dropped at RUN negedge 10 -> remaining 22 negedges emitted, 384-cycle pause, then IDLE; busy=0, frame_ready never asserted.
6. sys_rst asserted mid-RUN while clk_out=1 -> next cycle all outputs 0, state IDLE; re-enable restarts with a 3840-cycle long pause.
